blit_inner_seq: RTL and testbench

- Inner-loop sequencer of the blitter; the responder side of the outer-loop instart/indone handshake.
- On each instart it reloads an inner pixel counter from the latched inner count. It then steps through source-read, destination-read and destination-write memory phases per pixel, using a req/ack handshake.
- It returns a one-cycle indone pulse when the count is exhausted.
- It exports active/status so the outer loop can drive idle, bus-request and interrupt logic.

---
 rtl/blit_inner_seq_if.sv | 42 ++++
 rtl/blit_inner_seq.sv | 136 +++++++++++++
 tb/tb_blit_inner_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blit_inner_seq_if.sv
// ---------------------------------------------------------------------------
// blit_inner_seq_if
// Bundle of the inner-loop sequencer's control, handshake and memory signals.
//   gpu_din   GPU write data used by countld / cmdld
//   countld   load inner count register
//   cmdld     load srcen/dsten command bits
//   instart   start one inner loop (outer loop -> sequencer)
//   indone    one-cycle completion pulse (sequencer -> outer loop)
//   mreq/mack memory request / acknowledge handshake
//   mwrite    1 = write cycle, msrc 1 = source (A2) address
//   a1step    advance destination pointer, a2step advance source pointer
//   active    sequencer busy (not IDLE)
//   icount    live inner counter for status readback
// master: the outer loop / memory side; slave: the sequencer itself.
// ---------------------------------------------------------------------------
interface blit_inner_seq_if #(
  parameter int CNTW = 16
);
  logic [31:0]     gpu_din;
  logic            countld;
  logic            cmdld;
  logic            instart;
  logic            mack;
  logic            mreq;
  logic            mwrite;
  logic            msrc;
  logic            a1step;
  logic            a2step;
  logic            indone;
  logic            active;
  logic [CNTW-1:0] icount;

  modport master (
    output gpu_din, countld, cmdld, instart, mack,
    input  mreq, mwrite, msrc, a1step, a2step, indone, active, icount
  );

  modport slave (
    input  gpu_din, countld, cmdld, instart, mack,
    output mreq, mwrite, msrc, a1step, a2step, indone, active, icount
  );
endinterface

// File: rtl/blit_inner_seq.sv
// ---------------------------------------------------------------------------
// blit_inner_seq
// Inner-loop sequencer of the blitter. Responds to instart from the outer
// loop, walks source-read / destination-read / destination-write memory
// phases for each pixel and returns a one-cycle indone when the inner pixel
// count is exhausted.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    blit_inner_seq_if.slave (see interface header for members)
// ---------------------------------------------------------------------------
module blit_inner_seq #(
  parameter int CNTW = 16
) (
  input  logic           clk,
  input  logic           reset,
  blit_inner_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SREAD  = 3'd1,
    DREAD  = 3'd2,
    DWRITE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state_reg, state_next;
  logic [CNTW-1:0] inreload_reg;
  logic [CNTW-1:0] icount_reg;
  logic            srcen_reg, dsten_reg;
  logic            mreq_reg, mwrite_reg, msrc_reg;
  logic            a1step_reg, a2step_reg, indone_reg;
  logic            load_count, dec_count;
  state_t          first_phase;
  logic            next_is_access;

  // Entry phase of every pixel, chosen from the command bits.
  always_comb begin
    first_phase = DWRITE;
    if (srcen_reg)
      first_phase = SREAD;
    else if (dsten_reg)
      first_phase = DREAD;
  end

  always_comb begin
    state_next = state_reg;
    load_count = 1'b0;
    dec_count  = 1'b0;
    unique case (state_reg)
      IDLE, DONE: begin
        // DONE falls back to IDLE unless the outer loop chains a new
        // inner loop in the same cycle as indone.
        if (bus.instart) begin
          load_count = 1'b1;
          state_next = first_phase;
        end else begin
          state_next = IDLE;
        end
      end
      SREAD: begin
        if (bus.mack)
          state_next = dsten_reg ? DREAD : DWRITE;
      end
      DREAD: begin
        if (bus.mack)
          state_next = DWRITE;
      end
      DWRITE: begin
        if (bus.mack) begin
          dec_count = 1'b1;
          // Compare before decrement: a reload of 0 wraps to all-ones and
          // therefore runs the full 2^CNTW pixels.
          state_next = (icount_reg == CNT_ONE) ? DONE : first_phase;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign next_is_access = (state_next == SREAD) || (state_next == DREAD) ||
                          (state_next == DWRITE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      inreload_reg <= '0;
      icount_reg   <= '0;
      srcen_reg    <= 1'b0;
      dsten_reg    <= 1'b0;
      mreq_reg     <= 1'b0;
      mwrite_reg   <= 1'b0;
      msrc_reg     <= 1'b0;
      a1step_reg   <= 1'b0;
      a2step_reg   <= 1'b0;
      indone_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;

      // Loads only affect the value picked up by the next instart.
      if (bus.countld)
        inreload_reg <= bus.gpu_din[CNTW-1:0];
      if (bus.cmdld) begin
        srcen_reg <= bus.gpu_din[0];
        dsten_reg <= bus.gpu_din[1];
      end

      if (load_count)
        icount_reg <= inreload_reg;
      else if (dec_count)
        icount_reg <= icount_reg - CNT_ONE;

      // Outputs are registered from the next state so they line up with
      // the state they describe; back-to-back phases keep mreq high.
      mreq_reg   <= next_is_access;
      mwrite_reg <= (state_next == DWRITE);
      msrc_reg   <= (state_next == SREAD);
      a2step_reg <= (state_reg == SREAD) && bus.mack;
      a1step_reg <= (state_reg == DWRITE) && bus.mack;
      indone_reg <= (state_next == DONE);
    end
  end

  assign bus.mreq   = mreq_reg;
  assign bus.mwrite = mwrite_reg;
  assign bus.msrc   = msrc_reg;
  assign bus.a1step = a1step_reg;
  assign bus.a2step = a2step_reg;
  assign bus.indone = indone_reg;
  assign bus.icount = icount_reg;
  assign bus.active = (state_reg != IDLE);

endmodule

// File: tb/tb_blit_inner_seq.sv
// ---------------------------------------------------------------------------
// tb_blit_inner_seq
// Directed self-checking bench for blit_inner_seq. A 16-bit-counter instance
// covers the handshake scenarios; a 4-bit-counter instance covers the
// zero-reload wrap to 2^CNTW pixels.
// ---------------------------------------------------------------------------
module tb_blit_inner_seq;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  // Chained-loop monitor state
  logic mon_en;
  int   mon_indone;
  int   mon_drops;

  blit_inner_seq_if #(.CNTW(16)) bi ();
  blit_inner_seq_if #(.CNTW(4))  bs ();

  blit_inner_seq #(.CNTW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bi)
  );

  blit_inner_seq #(.CNTW(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instart during a memory phase is a protocol violation the bench never makes.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(bi.instart && bi.mreq)) else $error("instart during access (16-bit)");
      assert (!(bs.instart && bs.mreq)) else $error("instart during access (4-bit)");
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (bi.indone) mon_indone++;
      if (!bi.active) mon_drops++;
    end
  end

  // Waits (bounded) for mreq, samples the phase, acks it for one cycle and
  // returns the step strobes seen after the ack. Called at a negedge.
  task automatic serve(output logic ok, output logic wr, output logic src,
                       output logic a1, output logic a2);
    ok = 1'b0; wr = 1'b0; src = 1'b0; a1 = 1'b0; a2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bi.mreq === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      wr = bi.mwrite;
      src = bi.msrc;
      bi.mack = 1'b1;
      @(negedge clk);
      bi.mack = 1'b0;
      a1 = bi.a1step;
      a2 = bi.a2step;
      $display("[TB] access wr=%b src=%b a1step=%b a2step=%b icount=%0d", wr, src, a1, a2, bi.icount);
    end
  endtask

  task automatic load_regs(input logic [31:0] cnt, input logic [1:0] cmd);
    bi.gpu_din = cnt;
    bi.countld = 1'b1;
    @(negedge clk);
    bi.countld = 1'b0;
    bi.gpu_din = {30'd0, cmd};
    bi.cmdld = 1'b1;
    @(negedge clk);
    bi.cmdld = 1'b0;
    bi.gpu_din = '0;
  endtask

  task automatic pulse_instart();
    bi.instart = 1'b1;
    @(negedge clk);
    bi.instart = 1'b0;
  endtask

  task automatic test_reset();
    logic ok, wr, src, a1, a2;
    tests_run++;
    if (bi.mreq !== 1'b0 || bi.active !== 1'b0 || bi.indone !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got mreq=%b active=%b indone=%b, expected 0 0 0", bi.mreq, bi.active, bi.indone);
    end
    tests_run++;
    if (bi.icount !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_icount: got %0d expected 0", bi.icount);
    end
    // mack while idle must be ignored
    bi.mack = 1'b1;
    @(negedge clk);
    bi.mack = 1'b0;
    tests_run++;
    if (bi.a1step !== 1'b0 || bi.active !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_mack: got a1step=%b active=%b expected 0 0", bi.a1step, bi.active);
    end
    load_regs(32'd3, 2'b11);
    pulse_instart();
    serve(ok, wr, src, a1, a2);
    tests_run++;
    if (bi.mreq !== 1'b1 || bi.msrc !== 1'b0 || bi.mwrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL dread_before_reset: got mreq=%b msrc=%b mwrite=%b expected 1 0 0", bi.mreq, bi.msrc, bi.mwrite);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (bi.mreq !== 1'b0 || bi.active !== 1'b0 || bi.icount !== 16'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got mreq=%b active=%b icount=%0d expected 0 0 0", bi.mreq, bi.active, bi.icount);
    end
    @(negedge clk);
    reset = 1'b0;
    bi.mack = 1'b1;
    @(negedge clk);
    bi.mack = 1'b0;
    tests_run++;
    if (bi.active !== 1'b0 || bi.a1step !== 1'b0 || bi.a2step !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_mack: got active=%b a1step=%b a2step=%b expected 0 0 0", bi.active, bi.a1step, bi.a2step);
    end
    // inreload and command bits were cleared by reset: write-only, count 0
    pulse_instart();
    tests_run++;
    if (bi.mreq !== 1'b1 || bi.mwrite !== 1'b1 || bi.msrc !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_latency: got mreq=%b mwrite=%b msrc=%b expected 1 1 0", bi.mreq, bi.mwrite, bi.msrc);
    end
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_pixel();
    logic ok, wr, src, a1, a2;
    logic [4:0] exp_v [3];
    exp_v[0] = 5'b10101;  // ok wr src a1 a2 : source read
    exp_v[1] = 5'b10000;  // destination read
    exp_v[2] = 5'b11010;  // destination write
    load_regs(32'd3, 2'b11);
    pulse_instart();
    for (int p = 0; p < 3; p++) begin
      for (int ph = 0; ph < 3; ph++) begin
        serve(ok, wr, src, a1, a2);
        tests_run++;
        if ({ok, wr, src, a1, a2} !== exp_v[ph]) begin
          tests_failed++;
          $display("FAIL full_pixel%0d_phase%0d: got ok,wr,src,a1,a2=%b expected %b", p, ph, {ok, wr, src, a1, a2}, exp_v[ph]);
        end
      end
    end
    tests_run++;
    if (bi.indone !== 1'b1 || bi.icount !== 16'd0 || bi.active !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_done: got indone=%b icount=%0d active=%b expected 1 0 1", bi.indone, bi.icount, bi.active);
    end
    @(negedge clk);
    tests_run++;
    if (bi.indone !== 1'b0 || bi.active !== 1'b0 || bi.mreq !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_idle: got indone=%b active=%b mreq=%b expected 0 0 0", bi.indone, bi.active, bi.mreq);
    end
  endtask

  task automatic test_write_only();
    logic ok, wr, src, a1, a2;
    int held;
    load_regs(32'd2, 2'b00);
    pulse_instart();
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (bi.mreq === 1'b1 && bi.a1step === 1'b0 && bi.icount === 16'd2) held++;
      @(negedge clk);
    end
    tests_run++;
    if (held !== 5) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d held cycles expected 5", held);
    end
    for (int p = 0; p < 2; p++) begin
      serve(ok, wr, src, a1, a2);
      tests_run++;
      if ({ok, wr, src, a1, a2} !== 5'b11010) begin
        tests_failed++;
        $display("FAIL write_only%0d: got ok,wr,src,a1,a2=%b expected 11010", p, {ok, wr, src, a1, a2});
      end
    end
    tests_run++;
    if (bi.indone !== 1'b1 || bi.icount !== 16'd0) begin
      tests_failed++;
      $display("FAIL write_only_done: got indone=%b icount=%0d expected 1 0", bi.indone, bi.icount);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic ok, wr, src, a1, a2;
    load_regs(32'd1, 2'b00);
    mon_indone = 0;
    mon_drops = 0;
    pulse_instart();
    #1 mon_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(ok, wr, src, a1, a2);
      tests_run++;
      if (bi.indone !== 1'b1 || ok !== 1'b1) begin
        tests_failed++;
        $display("FAIL chain%0d_done: got indone=%b ok=%b expected 1 1", k, bi.indone, ok);
      end
      if (k < 3) begin
        pulse_instart();
        tests_run++;
        if (bi.mreq !== 1'b1 || bi.icount !== 16'd1) begin
          tests_failed++;
          $display("FAIL chain%0d_restart: got mreq=%b icount=%0d expected 1 1", k, bi.mreq, bi.icount);
        end
      end
    end
    #1 mon_en = 1'b0;
    tests_run++;
    if (mon_indone !== 4 || mon_drops !== 0) begin
      tests_failed++;
      $display("FAIL chain_monitor: got indone pulses=%0d active drops=%0d expected 4 0", mon_indone, mon_drops);
    end
    @(negedge clk);
    tests_run++;
    if (bi.active !== 1'b0) begin
      tests_failed++;
      $display("FAIL chain_end_idle: got active=%b expected 0", bi.active);
    end
  endtask

  task automatic test_reload_during_run();
    logic ok, wr, src, a1, a2;
    int n;
    load_regs(32'd2, 2'b00);
    pulse_instart();
    serve(ok, wr, src, a1, a2);
    bi.gpu_din = 32'd5;
    bi.countld = 1'b1;
    @(negedge clk);
    bi.countld = 1'b0;
    bi.gpu_din = '0;
    tests_run++;
    if (bi.icount !== 16'd1 || bi.mreq !== 1'b1 || bi.mwrite !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_no_disturb: got icount=%0d mreq=%b mwrite=%b expected 1 1 1", bi.icount, bi.mreq, bi.mwrite);
    end
    serve(ok, wr, src, a1, a2);
    tests_run++;
    if (bi.indone !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_old_len: got indone=%b expected 1 after 2 pixels", bi.indone);
    end
    @(negedge clk);
    // countld together with instart: the old reload (5) is used this time
    bi.gpu_din = 32'd1;
    bi.countld = 1'b1;
    bi.instart = 1'b1;
    @(negedge clk);
    bi.countld = 1'b0;
    bi.instart = 1'b0;
    bi.gpu_din = '0;
    tests_run++;
    if (bi.icount !== 16'd5) begin
      tests_failed++;
      $display("FAIL simul_load_icount: got %0d expected 5", bi.icount);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      serve(ok, wr, src, a1, a2);
      if (!ok) break;
      n++;
      if (bi.indone === 1'b1) break;
    end
    tests_run++;
    if (n !== 5) begin
      tests_failed++;
      $display("FAIL reload_new_len: got %0d pixels expected 5", n);
    end
    @(negedge clk);
    pulse_instart();
    tests_run++;
    if (bi.icount !== 16'd1) begin
      tests_failed++;
      $display("FAIL simul_load_next: got icount=%0d expected 1", bi.icount);
    end
    serve(ok, wr, src, a1, a2);
    tests_run++;
    if (bi.indone !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_load_next_done: got indone=%b expected 1", bi.indone);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int a1n, dn;
    logic [3:0] cnt_at_done;
    cnt_at_done = 4'hF;
    bs.gpu_din = 32'h0000_FFF0;  // low 4 bits zero: 2^4 pixels
    bs.countld = 1'b1;
    @(negedge clk);
    bs.countld = 1'b0;
    bs.gpu_din = '0;
    bs.cmdld = 1'b1;
    @(negedge clk);
    bs.cmdld = 1'b0;
    bs.instart = 1'b1;
    @(negedge clk);
    bs.instart = 1'b0;
    bs.mack = 1'b1;
    a1n = 0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bs.a1step === 1'b1) a1n++;
      if (bs.indone === 1'b1) begin
        dn++;
        cnt_at_done = bs.icount;
        bs.mack = 1'b0;
      end
    end
    bs.mack = 1'b0;
    $display("[TB] wrap loop: %0d write acks, %0d indone", a1n, dn);
    tests_run++;
    if (a1n !== 16) begin
      tests_failed++;
      $display("FAIL wrap_acks: got %0d expected 16", a1n);
    end
    tests_run++;
    if (dn !== 1 || cnt_at_done !== 4'd0) begin
      tests_failed++;
      $display("FAIL wrap_done: got indone pulses=%0d icount=%0d expected 1 0", dn, cnt_at_done);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    mon_en = 1'b0;
    mon_indone = 0;
    mon_drops = 0;
    reset = 1'b1;
    bi.gpu_din = '0; bi.countld = 1'b0; bi.cmdld = 1'b0; bi.instart = 1'b0; bi.mack = 1'b0;
    bs.gpu_din = '0; bs.countld = 1'b0; bs.cmdld = 1'b0; bs.instart = 1'b0; bs.mack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_pixel();
    test_write_only();
    test_back_to_back();
    test_reload_during_run();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
